// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Holds default widths, the FSM state encoding and the first clear address.
// Optional feature macro: RF_X0_HARDWIRED_EN (register 0 is hardwired to zero,
// so the clear sequence skips it).
package rf_write_arbiter_pkg;

   localparam int unsigned RF_AW    = 5;
   localparam int unsigned RF_DW    = 32;
   localparam int unsigned RF_DEPTH = 32;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

`ifdef RF_X0_HARDWIRED_EN
   localparam int unsigned CLR_FIRST = 1;
`else
   localparam int unsigned CLR_FIRST = 0;
`endif

endpackage

// File: rtl/rf_write_arbiter_arb.sv
// 2-way round-robin arbiter.
// Ports:
//   clk, rst  clock / synchronous active-high reset
//   req[1:0]  request vector (bit 0 = A, bit 1 = B)
//   advance   arbitration is live this cycle; pointer may move
//   gnt[1:0]  gnt[i] high when requester i would be accepted if valid
// The pointer remembers the last contention winner (1 = B) and only moves when
// both requesters contend, so a lone requester never disturbs the alternation.
module rr_arb2
   import rf_write_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic ptr;

   // Pointer starts at B so A wins the first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b1;
      end else if (advance && (&req)) begin
         ptr <= ~ptr;
      end
   end

   // A requester is blocked only when the other one is requesting and owns the turn;
   // this keeps each grant independent of the requester's own request bit.
   always_comb begin
      gnt    = 2'b00;
      gnt[0] = ~(req[1] & ~ptr);
      gnt[1] = ~(req[0] & ptr);
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single write port of the 32x32 register file between requester A
// (ALU writeback) and requester B (load unit) with round-robin arbitration, and
// sequences a full-file clear on request.
// Ports:
//   CLK, RST                 clock / synchronous active-high reset
//   A_VALID/A_READY/A_ADDR/A_DATA   requester A write handshake
//   B_VALID/B_READY/B_ADDR/B_DATA   requester B write handshake
//   CLR_REQ                  start a clear (sampled in IDLE only)
//   CLR_DONE                 one-cycle pulse when the clear completes
//   BUSY                     high while clearing
//   RF_WE3/RF_A3/RF_WD3      registered write port to the register file
// Optional feature macro: RF_X0_HARDWIRED_EN (writes to address 0 are accepted
// but never reach the register file; clear starts at address 1).
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int unsigned AW    = RF_AW,
   parameter int unsigned DW    = RF_DW,
   parameter int unsigned DEPTH = RF_DEPTH
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          A_VALID,
   output logic          A_READY,
   input  logic [AW-1:0] A_ADDR,
   input  logic [DW-1:0] A_DATA,
   input  logic          B_VALID,
   output logic          B_READY,
   input  logic [AW-1:0] B_ADDR,
   input  logic [DW-1:0] B_DATA,
   input  logic          CLR_REQ,
   output logic          CLR_DONE,
   output logic          BUSY,
   output logic          RF_WE3,
   output logic [AW-1:0] RF_A3,
   output logic [DW-1:0] RF_WD3
);

   state_e        state;
   state_e        state_nxt;
   logic [AW-1:0] clr_cnt;
   logic          clr_last;
   logic [1:0]    gnt;
   logic          arb_adv;
   logic          a_acc;
   logic          b_acc;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;
   logic          x0_block;
   logic          wr_we_nxt;
   logic [AW-1:0] wr_a_nxt;
   logic [DW-1:0] wr_d_nxt;

   assign clr_last = (clr_cnt == AW'(DEPTH - 1));

   rr_arb2 u_arb (
      .clk     (CLK),
      .rst     (RST),
      .req     ({B_VALID, A_VALID}),
      .advance (arb_adv),
      .gnt     (gnt)
   );

   // Accepts derived from the grant, not from READY, to keep the comb path acyclic.
   assign a_acc    = A_VALID & gnt[0];
   assign b_acc    = B_VALID & gnt[1];
   assign sel_addr = b_acc ? B_ADDR : A_ADDR;
   assign sel_data = b_acc ? B_DATA : A_DATA;

`ifdef RF_X0_HARDWIRED_EN
   assign x0_block = (sel_addr == '0);
`else
   assign x0_block = 1'b0;
`endif

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (CLR_REQ) state_nxt = ST_CLEAR;
         ST_CLEAR: if (clr_last) state_nxt = ST_IDLE;
      endcase
   end

   // Handshake and write-port decode; a clear request blocks both requesters.
   always_comb begin
      A_READY   = 1'b0;
      B_READY   = 1'b0;
      arb_adv   = 1'b0;
      wr_we_nxt = 1'b0;
      wr_a_nxt  = RF_A3;
      wr_d_nxt  = RF_WD3;
      case (state)
         ST_IDLE: begin
            if (!CLR_REQ) begin
               A_READY = gnt[0];
               B_READY = gnt[1];
               arb_adv = 1'b1;
               if ((a_acc || b_acc) && !x0_block) begin
                  wr_we_nxt = 1'b1;
                  wr_a_nxt  = sel_addr;
                  wr_d_nxt  = sel_data;
               end
            end
         end
         ST_CLEAR: begin
            wr_we_nxt = 1'b1;
            wr_a_nxt  = clr_cnt;
            wr_d_nxt  = '0;
         end
      endcase
   end

   // Registered write port, status flags and clear counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         RF_WE3   <= 1'b0;
         RF_A3    <= '0;
         RF_WD3   <= '0;
         CLR_DONE <= 1'b0;
         BUSY     <= 1'b0;
         clr_cnt  <= '0;
      end else begin
         RF_WE3   <= wr_we_nxt;
         RF_A3    <= wr_a_nxt;
         RF_WD3   <= wr_d_nxt;
         CLR_DONE <= (state == ST_CLEAR) && clr_last;
         BUSY     <= (state_nxt == ST_CLEAR);
         if (state == ST_IDLE) begin
            if (CLR_REQ) clr_cnt <= AW'(CLR_FIRST);
         end else if (clr_last) begin
            clr_cnt <= '0;
         end else begin
            clr_cnt <= clr_cnt + AW'(1);
         end
      end
   end

endmodule
